// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage access controller and MEM/WB register.
package mem_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   typedef struct packed {
      logic        we;
      logic        rd_sel;
      logic        next_pc;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] alu;
   } mem_req_t;

   localparam int          DEF_TIMEOUT  = 64;
   localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_wb_stage.sv
// MEM-stage data-memory access FSM plus MEM/WB pipeline register; stalls upstream while an access is outstanding.
// Optional stall-cycle counter output perf_stall_cnt is built when MEM_PERF_CNT_EN is defined.
import mem_pkg::*;

module mem_wb_stage #(
   parameter int          TIMEOUT  = DEF_TIMEOUT,
   parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_VALID,
   input  logic        MEM_DM_WE,
   input  logic        MEM_RF_D_SEL,
   input  logic [31:0] MEM_ALU_RES,
   input  logic [31:0] MEM_muxB,
   input  logic [15:0] MEM_DM_ADDR,
   input  logic        MEM_NEXT_PC,
   output logic        dm_req,
   output logic        dm_we,
   output logic [15:0] dm_addr,
   output logic [31:0] dm_wdata,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        MEM_STALL,
   output logic        WB_VALID,
   output logic [31:0] WB_RF_DATA,
   output logic        WB_NEXT_PC,
   output logic        WB_RF_D_SEL,
   output logic        dm_err
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt
`endif
);

   localparam int             CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]  CNT_MAX  = '1;

   mem_state_t    state;
   mem_req_t      req;
   logic [CW-1:0] cnt;

   logic acc;
   logic in_wait;
   logic timeout;
   logic rd_from_mem;

   assign acc         = MEM_VALID & (MEM_DM_WE | MEM_RF_D_SEL);
   assign in_wait     = (state == WAIT);
   // An ack in the last allowed cycle still wins over the timeout.
   assign timeout     = in_wait & ~dm_ack & (cnt == CNT_LAST);
   assign rd_from_mem = req.rd_sel & ~req.we;

   assign dm_req   = in_wait;
   assign dm_we    = in_wait & req.we;
   assign dm_addr  = in_wait ? req.addr  : 16'h0;
   assign dm_wdata = in_wait ? req.wdata : 32'h0;

   assign MEM_STALL = ~rst & (in_wait ? (~dm_ack & ~timeout) : acc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req         <= '0;
         cnt         <= '0;
         WB_VALID    <= 1'b0;
         WB_RF_DATA  <= 32'h0;
         WB_NEXT_PC  <= 1'b0;
         WB_RF_D_SEL <= 1'b0;
         dm_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (acc) begin
                  req.we      <= MEM_DM_WE;
                  req.rd_sel  <= MEM_RF_D_SEL;
                  req.next_pc <= MEM_NEXT_PC;
                  req.addr    <= MEM_DM_ADDR;
                  req.wdata   <= MEM_muxB;
                  req.alu     <= MEM_ALU_RES;
                  cnt         <= '0;
                  state       <= WAIT;
                  WB_VALID    <= 1'b0;
               end else begin
                  WB_VALID    <= MEM_VALID;
                  WB_RF_DATA  <= MEM_ALU_RES;
                  WB_NEXT_PC  <= MEM_NEXT_PC;
                  WB_RF_D_SEL <= MEM_RF_D_SEL;
               end
            end
            WAIT: begin
               if (dm_ack || timeout) begin
                  state       <= IDLE;
                  WB_VALID    <= 1'b1;
                  WB_NEXT_PC  <= req.next_pc;
                  WB_RF_D_SEL <= req.rd_sel;
                  if (rd_from_mem)
                     WB_RF_DATA <= dm_ack ? dm_rdata : ERR_DATA;
                  else
                     WB_RF_DATA <= req.alu;
                  if (timeout)
                     dm_err <= 1'b1;
               end else begin
                  WB_VALID <= 1'b0;
                  if (cnt != CNT_MAX)
                     cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         perf_stall_cnt <= 32'h0;
      else if (MEM_STALL)
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: inputs driven on the falling edge, outputs checked 1 time unit later.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_VALID, MEM_DM_WE, MEM_RF_D_SEL, MEM_NEXT_PC;
   logic [31:0] MEM_ALU_RES, MEM_muxB;
   logic [15:0] MEM_DM_ADDR;
   logic        dm_req, dm_we, dm_ack;
   logic [15:0] dm_addr;
   logic [31:0] dm_wdata, dm_rdata;
   logic        MEM_STALL, WB_VALID, WB_NEXT_PC, WB_RF_D_SEL, dm_err;
   logic [31:0] WB_RF_DATA;
`ifdef MEM_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
`endif

   int checks = 0;
   int passed = 0;
   int fails  = 0;
   int req_cycles;
   int stall_cycles;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst),
      .MEM_VALID(MEM_VALID), .MEM_DM_WE(MEM_DM_WE), .MEM_RF_D_SEL(MEM_RF_D_SEL),
      .MEM_ALU_RES(MEM_ALU_RES), .MEM_muxB(MEM_muxB), .MEM_DM_ADDR(MEM_DM_ADDR),
      .MEM_NEXT_PC(MEM_NEXT_PC),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .MEM_STALL(MEM_STALL), .WB_VALID(WB_VALID), .WB_RF_DATA(WB_RF_DATA),
      .WB_NEXT_PC(WB_NEXT_PC), .WB_RF_D_SEL(WB_RF_D_SEL), .dm_err(dm_err)
`ifdef MEM_PERF_CNT_EN
      , .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".dm_req"},      32'(dm_req),      32'h0);
      chk({tag, ".dm_we"},       32'(dm_we),       32'h0);
      chk({tag, ".dm_addr"},     32'(dm_addr),     32'h0);
      chk({tag, ".dm_wdata"},    dm_wdata,         32'h0);
      chk({tag, ".MEM_STALL"},   32'(MEM_STALL),   32'h0);
      chk({tag, ".WB_VALID"},    32'(WB_VALID),    32'h0);
      chk({tag, ".WB_RF_DATA"},  WB_RF_DATA,       32'h0);
      chk({tag, ".WB_NEXT_PC"},  32'(WB_NEXT_PC),  32'h0);
      chk({tag, ".WB_RF_D_SEL"}, 32'(WB_RF_D_SEL), 32'h0);
      chk({tag, ".dm_err"},      32'(dm_err),      32'h0);
   endtask

   task automatic set_inst(input logic v, input logic we, input logic rsel,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [15:0] addr, input logic npc);
      MEM_VALID = v; MEM_DM_WE = we; MEM_RF_D_SEL = rsel;
      MEM_ALU_RES = alu; MEM_muxB = wd; MEM_DM_ADDR = addr; MEM_NEXT_PC = npc;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      repeat (2) @(posedge clk);
      tick();
      chk_all_zero("reset");
      rst = 1'b0;

      // ALU op: one-cycle pass-through, no memory traffic
      tick();
      set_inst(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 16'h0, 1'b1);
      #1;
      chk("alu.stall", 32'(MEM_STALL), 32'h0);
      chk("alu.req",   32'(dm_req),    32'h0);
      tick();
      chk("alu.wb_valid", 32'(WB_VALID),    32'h1);
      chk("alu.wb_data",  WB_RF_DATA,       32'h1234);
      chk("alu.wb_npc",   32'(WB_NEXT_PC),  32'h1);
      chk("alu.wb_dsel",  32'(WB_RF_D_SEL), 32'h0);
      chk("alu.req2",     32'(dm_req),      32'h0);
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      tick();
      chk("alu.bubble", 32'(WB_VALID), 32'h0);

      // Load, ack in third WAIT cycle
      set_inst(1'b1, 1'b0, 1'b1, 32'h77, 32'h0, 16'h0040, 1'b0);
      #1;
      chk("ld.idle_stall", 32'(MEM_STALL), 32'h1);
      chk("ld.idle_req",   32'(dm_req),    32'h0);
      req_cycles = 0; stall_cycles = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) begin dm_ack = 1'b1; dm_rdata = 32'hCAFE0001; #1; end
         if (dm_req) req_cycles++;
         if (MEM_STALL) stall_cycles++;
         chk("ld.addr", 32'(dm_addr), 32'h0040);
         chk("ld.we",   32'(dm_we),   32'h0);
         if (i == 1) chk("ld.wb_valid_wait", 32'(WB_VALID), 32'h0);
      end
      chk("ld.req_cycles",   req_cycles,   3);
      chk("ld.stall_cycles", stall_cycles, 3);
      tick();
      dm_ack = 1'b0; dm_rdata = 32'h0;
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      chk("ld.wb_valid", 32'(WB_VALID),    32'h1);
      chk("ld.wb_data",  WB_RF_DATA,       32'hCAFE0001);
      chk("ld.wb_dsel",  32'(WB_RF_D_SEL), 32'h1);
      chk("ld.req_done", 32'(dm_req),      32'h0);

      // Store, ack in first WAIT cycle
      set_inst(1'b1, 1'b1, 1'b0, 32'h55, 32'hA5A5A5A5, 16'h0010, 1'b1);
      #1;
      chk("st.idle_stall", 32'(MEM_STALL), 32'h1);
      tick();
      dm_ack = 1'b1;
      #1;
      chk("st.req",   32'(dm_req),   32'h1);
      chk("st.we",    32'(dm_we),    32'h1);
      chk("st.addr",  32'(dm_addr),  32'h0010);
      chk("st.wdata", dm_wdata,      32'hA5A5A5A5);
      chk("st.stall", 32'(MEM_STALL), 32'h0);
      tick();
      dm_ack = 1'b0;
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      chk("st.wb_valid", 32'(WB_VALID),   32'h1);
      chk("st.wb_data",  WB_RF_DATA,      32'h55);
      chk("st.wb_npc",   32'(WB_NEXT_PC), 32'h1);
      chk("st.we_off",   32'(dm_we),      32'h0);

      // Load with no ack: 64 request cycles then abort
      set_inst(1'b1, 1'b0, 1'b1, 32'h99, 32'h0, 16'h0080, 1'b0);
      req_cycles = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (!dm_req) break;
         req_cycles++;
         if (!MEM_STALL) begin
            chk("to.err_before", 32'(dm_err), 32'h0);
            set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
         end
      end
      chk("to.req_cycles", req_cycles,       64);
      chk("to.err",        32'(dm_err),      32'h1);
      chk("to.wb_valid",   32'(WB_VALID),    32'h1);
      chk("to.wb_data",    WB_RF_DATA,       32'hDEADBEEF);
      set_inst(1'b1, 1'b0, 1'b0, 32'h4321, 32'h0, 16'h0, 1'b0);
      tick();
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      chk("to.err_sticky", 32'(dm_err), 32'h1);
      chk("to.alu_after",  WB_RF_DATA,  32'h4321);

      // Reset in second WAIT cycle, late ack afterwards
      set_inst(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0020, 1'b0);
      tick();
      chk("rst.wait1_req", 32'(dm_req), 32'h1);
      tick();
      rst = 1'b1;
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      tick();
      rst = 1'b0;
      dm_ack = 1'b1; dm_rdata = 32'h1111;
      #1;
      chk_all_zero("rst_mid");
      tick();
      dm_ack = 1'b0; dm_rdata = 32'h0;
      chk("rst.late_ack_valid", 32'(WB_VALID), 32'h0);
      chk("rst.late_ack_data",  WB_RF_DATA,    32'h0);
      chk("rst.late_ack_req",   32'(dm_req),   32'h0);

      // Back-to-back load then ALU op
      set_inst(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0030, 1'b0);
      tick();
      dm_ack = 1'b1; dm_rdata = 32'hBEEF0002;
      #1;
      chk("b2b.stall_ack", 32'(MEM_STALL), 32'h0);
      tick();
      dm_ack = 1'b0;
      chk("b2b.ld_valid", 32'(WB_VALID), 32'h1);
      chk("b2b.ld_data",  WB_RF_DATA,    32'hBEEF0002);
      set_inst(1'b1, 1'b0, 1'b0, 32'hABCD, 32'h0, 16'h0, 1'b1);
      #1;
      chk("b2b.alu_stall", 32'(MEM_STALL), 32'h0);
      tick();
      chk("b2b.alu_valid", 32'(WB_VALID), 32'h1);
      chk("b2b.alu_data",  WB_RF_DATA,    32'hABCD);
      set_inst(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'h0, 1'b0);
      tick();
      chk("b2b.drain", 32'(WB_VALID), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
